// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between up to four requesters and the shared-ALU arbiter.
// Each per-requester field is packed with requester k in slice k.
interface alu_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        iReqValid;
  logic [NUM_REQ-1:0]        oReqReady;
  logic [DATA_W*NUM_REQ-1:0] iReqDataA;
  logic [DATA_W*NUM_REQ-1:0] iReqDataB;
  logic [3*NUM_REQ-1:0]      iReqFunct3;
  logic [7*NUM_REQ-1:0]      iReqFunct7;
  logic [NUM_REQ-1:0]        oRspValid;
  logic [NUM_REQ-1:0]        iRspReady;
  logic [DATA_W-1:0]         oRspData;
  logic                      oRspZero;
  logic                      oBusy;

  modport master (
    output iReqValid, iReqDataA, iReqDataB, iReqFunct3, iReqFunct7, iRspReady,
    input  oReqReady, oRspValid, oRspData, oRspZero, oBusy
  );

  modport slave (
    input  iReqValid, iReqDataA, iReqDataB, iReqFunct3, iReqFunct7, iRspReady,
    output oReqReady, oRspValid, oRspData, oRspZero, oBusy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one combinational RV32 ALU among NUM_REQ requesters.
// One operation in flight: IDLE grants and latches, EXEC evaluates, RESP holds the result.
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32
) (
  input logic                iClk,
  input logic                iRst,
  alu_share_arbiter_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned ShW  = $clog2(DATA_W);

  typedef enum logic [1:0] {StIdle, StExec, StResp} stateT;

  stateT              stateQ, stateD;
  logic [IdxW-1:0]    lastQ, lastD;
  logic [IdxW-1:0]    ownerQ, ownerD;
  logic [DATA_W-1:0]  opAQ, opAD, opBQ, opBD;
  logic [2:0]         funct3Q, funct3D;
  logic [6:0]         funct7Q, funct7D;
  logic [DATA_W-1:0]  resultQ, resultD;
  logic               zeroQ, zeroD;
  logic [NUM_REQ-1:0] rspValidQ, rspValidD;

  logic [IdxW-1:0]    grantIdx;
  logic [IdxW-1:0]    cand;
  logic               grantFound;
  logic [NUM_REQ-1:0] reqReady;

  logic [DATA_W-1:0]  aluResult;
  logic               aluZero;
  logic               aluAlt;
  logic               lessS;
  logic               lessU;
  logic [ShW-1:0]     shamt;

  // Search starts just past the last requester served.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(lastQ) + i) % NUM_REQ);
      if (!grantFound && bus.iReqValid[cand]) begin
        grantFound = 1'b1;
        grantIdx   = cand;
      end
    end
  end

  // Ready is held low during reset so nothing is accepted while state is being cleared.
  always_comb begin
    reqReady = '0;
    if (stateQ == StIdle && grantFound && !iRst) begin
      reqReady[grantIdx] = 1'b1;
    end
  end

  always_comb begin
    stateD    = stateQ;
    lastD     = lastQ;
    ownerD    = ownerQ;
    opAD      = opAQ;
    opBD      = opBQ;
    funct3D   = funct3Q;
    funct7D   = funct7Q;
    resultD   = resultQ;
    zeroD     = zeroQ;
    rspValidD = rspValidQ;

    unique case (stateQ)
      StIdle: begin
        if (grantFound) begin
          ownerD = grantIdx;
          stateD = StExec;
          for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grantIdx == IdxW'(k)) begin
              opAD    = bus.iReqDataA[k*DATA_W +: DATA_W];
              opBD    = bus.iReqDataB[k*DATA_W +: DATA_W];
              funct3D = bus.iReqFunct3[k*3 +: 3];
              funct7D = bus.iReqFunct7[k*7 +: 7];
            end
          end
        end
      end
      StExec: begin
        resultD           = aluResult;
        zeroD             = aluZero;
        rspValidD         = '0;
        rspValidD[ownerQ] = 1'b1;
        stateD            = StResp;
      end
      StResp: begin
        // Only the owner's ready completes the handshake.
        if (bus.iRspReady[ownerQ]) begin
          rspValidD = '0;
          lastD     = ownerQ;
          stateD    = StIdle;
        end
      end
      default: begin
        stateD    = StIdle;
        rspValidD = '0;
      end
    endcase
  end

  // Single ALU instance, fed only from the latched operands.
  always_comb begin
    aluResult = '0;
    aluAlt    = (funct7Q == 7'h20);
    lessS     = $signed(opAQ) < $signed(opBQ);
    lessU     = opAQ < opBQ;
    shamt     = (opBQ > DATA_W'(DATA_W - 1)) ? ShW'(DATA_W - 1) : opBQ[ShW-1:0];

    unique case (funct3Q)
      3'b000: aluResult = aluAlt ? (opAQ - opBQ) : (opAQ + opBQ);
      3'b001: aluResult = opAQ << shamt;
      3'b010: aluResult = DATA_W'(lessS);
      3'b011: aluResult = DATA_W'(lessU);
      3'b100: aluResult = opAQ ^ opBQ;
      3'b101: aluResult = aluAlt ? DATA_W'($signed(opAQ) >>> shamt) : (opAQ >> shamt);
      3'b110: aluResult = opAQ | opBQ;
      3'b111: aluResult = opAQ & opBQ;
    endcase

    aluZero = (aluResult == '0);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateQ    <= StIdle;
      lastQ     <= IdxW'(NUM_REQ - 1);
      ownerQ    <= '0;
      opAQ      <= '0;
      opBQ      <= '0;
      funct3Q   <= '0;
      funct7Q   <= '0;
      resultQ   <= '0;
      zeroQ     <= 1'b0;
      rspValidQ <= '0;
    end else begin
      stateQ    <= stateD;
      lastQ     <= lastD;
      ownerQ    <= ownerD;
      opAQ      <= opAD;
      opBQ      <= opBD;
      funct3Q   <= funct3D;
      funct7Q   <= funct7D;
      resultQ   <= resultD;
      zeroQ     <= zeroD;
      rspValidQ <= rspValidD;
    end
  end

  assign bus.oReqReady = reqReady;
  assign bus.oRspValid = rspValidQ;
  assign bus.oRspData  = resultQ;
  assign bus.oRspZero  = zeroQ;
  assign bus.oBusy     = (stateQ != StIdle);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: stimulus pushes expected responses, a negedge
// monitor pops and compares them on every response handshake.
module tb_alu_share_arbiter;
  logic clk;
  logic rst;

  alu_share_arbiter_if #(.NUM_REQ(2), .DATA_W(32)) bus ();

  alu_share_arbiter #(.NUM_REQ(2), .DATA_W(32)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  typedef struct {
    int          owner;
    logic [31:0] data;
    logic        zero;
  } expT;

  expT expQ[$];
  expT e;
  int  errors = 0;
  int  checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic pushExp(input int owner, input logic [31:0] data, input logic zero);
    expT x;
    x.owner = owner;
    x.data  = data;
    x.zero  = zero;
    expQ.push_back(x);
  endtask

  task automatic drive(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3, input logic [6:0] f7);
    bus.iReqDataA[k*32 +: 32] = a;
    bus.iReqDataB[k*32 +: 32] = b;
    bus.iReqFunct3[k*3 +: 3]  = f3;
    bus.iReqFunct7[k*7 +: 7]  = f7;
    bus.iReqValid[k]          = 1'b1;
  endtask

  // Waits (bounded) for this requester's grant, then drops valid after the accepting edge.
  task automatic waitGrant(input int k);
    bit ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (bus.oReqReady[k]) ok = 1'b1;
    end
    if (ok) begin
      check("grantOneHot", 32'(bus.oReqReady), 32'(1 << k));
    end else begin
      checks++;
      errors++;
      $display("FAIL grantTimeout: requester %0d got no ready, expected a grant", k);
    end
    @(posedge clk);
    #1;
    bus.iReqValid[k] = 1'b0;
  endtask

  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3, input logic [6:0] f7);
    drive(k, a, b, f3, f7);
    waitGrant(k);
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 100 && (expQ.size() != 0 || bus.oBusy); c++) @(negedge clk);
    check("drainPending", 32'(expQ.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Single isolated operation with latency checks: EXEC one cycle, then RESP.
  task automatic runOne(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] expD, input logic expZ);
    pushExp(k, expD, expZ);
    issue(k, a, b, f3, f7);
    @(negedge clk);
    check("execBusy", 32'(bus.oBusy), 32'd1);
    check("execNoValid", 32'(bus.oRspValid), 32'd0);
    @(negedge clk);
    check("rspLatency", 32'(bus.oRspValid), 32'(1 << k));
    waitDrain();
  endtask

  // Monitor: any cycle with a valid response must have no grant; handshakes pop the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.oRspValid != '0) begin
      check("noGrantInResp", 32'(bus.oReqReady), 32'd0);
      if ((bus.oRspValid & bus.iRspReady) != '0) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpectedRsp: got valid %b data %h, expected none", bus.oRspValid,
                   bus.oRspData);
        end else begin
          e = expQ.pop_front();
          check("rspOwner", 32'(bus.oRspValid), 32'(1 << e.owner));
          check("rspData", bus.oRspData, e.data);
          check("rspZero", 32'(bus.oRspZero), 32'(e.zero));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.iReqValid  = '0;
    bus.iReqDataA  = '0;
    bus.iReqDataB  = '0;
    bus.iReqFunct3 = '0;
    bus.iReqFunct7 = '0;
    bus.iRspReady  = '1;

    // Reset state, with requests asserted to show ready stays low.
    bus.iReqValid = 2'b11;
    @(negedge clk);
    check("resetReqReady", 32'(bus.oReqReady), 32'd0);
    check("resetRspValid", 32'(bus.oRspValid), 32'd0);
    check("resetRspData", bus.oRspData, 32'd0);
    check("resetRspZero", 32'(bus.oRspZero), 32'd0);
    check("resetBusy", 32'(bus.oBusy), 32'd0);
    bus.iReqValid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single ADD and SUB-to-zero.
    runOne(0, 32'd5, 32'd7, 3'b000, 7'h00, 32'd12, 1'b0);
    runOne(1, 32'h1234, 32'h1234, 3'b000, 7'h20, 32'd0, 1'b1);

    // Fresh reset, then contention: grants must alternate 0,1,0,1.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    pushExp(0, 32'd2, 1'b0);
    pushExp(1, 32'h0000_00F0, 1'b0);
    pushExp(0, 32'h0000_00FF, 1'b0);
    pushExp(1, 32'd0, 1'b1);
    fork
      begin
        issue(0, 32'd1, 32'd1, 3'b000, 7'h00);
        issue(0, 32'hF0, 32'h0F, 3'b110, 7'h00);
      end
      begin
        issue(1, 32'hFF, 32'h0F, 3'b100, 7'h00);
        issue(1, 32'hF0, 32'h0F, 3'b111, 7'h00);
      end
    join
    waitDrain();

    // Backpressure on an SRA; a pending req1 (and requester 1's ready) must be ignored.
    pushExp(0, 32'hF800_0000, 1'b0);
    pushExp(1, 32'd5, 1'b0);
    bus.iRspReady = 2'b10;
    issue(0, 32'h8000_0000, 32'd4, 3'b101, 7'h20);
    drive(1, 32'd2, 32'd3, 3'b000, 7'h00);
    @(negedge clk);
    check("execReadyLow", 32'(bus.oReqReady), 32'd0);
    repeat (10) begin
      @(negedge clk);
      check("bpValid", 32'(bus.oRspValid), 32'd1);
      check("bpData", bus.oRspData, 32'hF800_0000);
      check("bpReady", 32'(bus.oReqReady), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.iRspReady = '1;
    waitGrant(1);
    waitDrain();

    // Shift saturation and compares.
    runOne(0, 32'd1, 32'h40, 3'b001, 7'h00, 32'h8000_0000, 1'b0);
    runOne(0, 32'd1, 32'hFFFF_FFFF, 3'b011, 7'h00, 32'd1, 1'b0);
    runOne(0, 32'hFFFF_FFFF, 32'd1, 3'b010, 7'h00, 32'd1, 1'b0);

    // Reset during EXEC: op dropped, pointer restored so req0 wins over req1.
    issue(0, 32'd9, 32'd9, 3'b000, 7'h00);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstRspValid", 32'(bus.oRspValid), 32'd0);
    check("rstBusy", 32'(bus.oBusy), 32'd0);
    check("rstRspData", bus.oRspData, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    pushExp(0, 32'd7, 1'b0);
    pushExp(1, 32'hFFFF_FFFF, 1'b0);
    fork
      issue(0, 32'd3, 32'd4, 3'b000, 7'h00);
      issue(1, 32'd3, 32'd4, 3'b000, 7'h20);
    join
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
